// File: rtl/timer_multi_apb.sv
`timescale 1ns/1ps
// timer_multi_apb
//   CH independent CNT_WIDTH-bit up/down timers behind a zero-wait-state APB
//   slave. The channels share one free-running 4-bit prescaler. Each channel
//   has its own reload value, auto-reload mode, sticky write-1-to-clear
//   overflow/underflow flags and an interrupt output.
//
//   Register map, channel n at n*0x10:
//     +0x0 TDR   reload value
//     +0x4 TCR   [7] LOAD [6] ARLD [5] DIR [4] EN [3] IE [1:0] CKS
//     +0x8 TSR   [0] OVF [1] UDF (W1C)
//     +0xC TCNT  live counter
//
// Ports
//   PCLK      clock, rising edge
//   PRESET    asynchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request
//   PRDATA    read data, combinational, 0 when not reading a mapped register
//   PREADY    tied to 1
//   PSLVERR   access phase to an unmapped address
//   TMR_OVF   per-channel overflow flag
//   TMR_URF   per-channel underflow flag
//   TMR_IRQ   per-channel IE & (OVF | UDF)
module timer_multi_apb #(
   parameter int CH         = 2,
   parameter int CNT_WIDTH  = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic [CH-1:0]         TMR_OVF,
   output logic [CH-1:0]         TMR_URF,
   output logic [CH-1:0]         TMR_IRQ
);

   localparam int                   IDX_W   = ADDR_WIDTH - 4;
   localparam logic [IDX_W-1:0]     CH_LIM  = IDX_W'(CH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [IDX_W-1:0]     ch_idx;
   logic [1:0]           reg_sel;
   logic                 mapped;
   logic                 wr_en;
   logic [3:0]           presc;

   logic [CNT_WIDTH-1:0] tdr     [CH];
   logic [7:0]           tcr     [CH];
   logic [CNT_WIDTH-1:0] cnt     [CH];
   logic [CNT_WIDTH-1:0] cnt_nxt [CH];
   logic [CH-1:0]        ovf, udf;
   logic [CH-1:0]        set_ovf, set_udf;
   logic [CH-1:0]        ch_hit, tick;
   logic [CH-1:0]        wr_tdr, wr_tcr, wr_tsr, wr_cnt;

   // PWDATA bits above the register widths are intentionally discarded.
   logic                 unused_pwdata;
   assign unused_pwdata = ^PWDATA;

   assign ch_idx  = PADDR[ADDR_WIDTH-1:4];
   assign reg_sel = PADDR[3:2];
   assign mapped  = (PADDR[1:0] == 2'b00) && (ch_idx < CH_LIM);
   assign wr_en   = PSEL && PENABLE && PWRITE && mapped;

   assign PREADY  = 1'b1;
   assign PSLVERR = PSEL && PENABLE && !mapped;
   assign TMR_OVF = ovf;
   assign TMR_URF = udf;

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         ch_hit[i]  = (ch_idx == IDX_W'(i));
         wr_tdr[i]  = wr_en && ch_hit[i] && (reg_sel == 2'd0);
         wr_tcr[i]  = wr_en && ch_hit[i] && (reg_sel == 2'd1);
         wr_tsr[i]  = wr_en && ch_hit[i] && (reg_sel == 2'd2);
         wr_cnt[i]  = wr_en && ch_hit[i] && (reg_sel == 2'd3);
         TMR_IRQ[i] = tcr[i][3] && (ovf[i] || udf[i]);
         case (tcr[i][1:0])
            2'd0:    tick[i] = presc[0];
            2'd1:    tick[i] = &presc[1:0];
            2'd2:    tick[i] = &presc[2:0];
            default: tick[i] = &presc;
         endcase
      end
   end

   // Next count: register write, then LOAD rising edge, then an enabled tick.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         cnt_nxt[i] = cnt[i];
         set_ovf[i] = 1'b0;
         set_udf[i] = 1'b0;
         if (wr_cnt[i]) begin
            cnt_nxt[i] = PWDATA[CNT_WIDTH-1:0];
         end else if (wr_tcr[i] && PWDATA[7] && !tcr[i][7]) begin
            cnt_nxt[i] = tdr[i];
         end else if (tick[i] && tcr[i][4]) begin
            if (!tcr[i][5]) begin
               if (cnt[i] == CNT_MAX) begin
                  cnt_nxt[i] = tcr[i][6] ? tdr[i] : '0;
                  set_ovf[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
               end
            end else begin
               if (cnt[i] == '0) begin
                  cnt_nxt[i] = tcr[i][6] ? tdr[i] : CNT_MAX;
                  set_udf[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = cnt[i] - CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         presc <= '0;
         ovf   <= '0;
         udf   <= '0;
         for (int i = 0; i < CH; i++) begin
            tdr[i] <= '0;
            tcr[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         presc <= presc + 4'd1;
         for (int i = 0; i < CH; i++) begin
            if (wr_tdr[i]) tdr[i] <= PWDATA[CNT_WIDTH-1:0];
            if (wr_tcr[i]) tcr[i] <= {PWDATA[7:3], 1'b0, PWDATA[1:0]};
            // A flag being set on the same edge as its W1C clear stays set.
            ovf[i] <= set_ovf[i] || (ovf[i] && !(wr_tsr[i] && PWDATA[0]));
            udf[i] <= set_udf[i] || (udf[i] && !(wr_tsr[i] && PWDATA[1]));
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE && mapped) begin
         for (int i = 0; i < CH; i++) begin
            if (ch_hit[i]) begin
               case (reg_sel)
                  2'd0:    PRDATA = DATA_WIDTH'(tdr[i]);
                  2'd1:    PRDATA = DATA_WIDTH'(tcr[i]);
                  2'd2:    PRDATA = DATA_WIDTH'({udf[i], ovf[i]});
                  default: PRDATA = DATA_WIDTH'(cnt[i]);
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_multi_apb.sv
`timescale 1ns/1ps
// Directed bench for timer_multi_apb (CH=2, CNT_WIDTH=16). APB transfers push
// their expected PRDATA/PSLVERR into a queue; a monitor pops and compares at
// the access phase. Side-band outputs are compared directly.
module tb_timer_multi_apb;
   localparam int CH = 2;
   localparam int CW = 16;
   localparam int AW = 8;
   localparam int DW = 32;

   logic          PCLK    = 1'b0;
   logic          PRESET  = 1'b1;
   logic          PSEL    = 1'b0;
   logic          PENABLE = 1'b0;
   logic          PWRITE  = 1'b0;
   logic [AW-1:0] PADDR   = '0;
   logic [DW-1:0] PWDATA  = '0;
   logic [DW-1:0] PRDATA;
   logic          PREADY, PSLVERR;
   logic [CH-1:0] TMR_OVF, TMR_URF, TMR_IRQ;

   timer_multi_apb #(.CH(CH), .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .TMR_OVF(TMR_OVF), .TMR_URF(TMR_URF), .TMR_IRQ(TMR_IRQ)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   // Model of the shared prescaler phase, used to place a write on a tick edge.
   logic [3:0] pcnt;
   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) pcnt <= 4'd0;
      else        pcnt <= pcnt + 4'd1;
   end

   logic          exp_rd_q   [$];
   logic [DW-1:0] exp_data_q [$];
   logic          exp_err_q  [$];
   string         exp_name_q [$];

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   logic          mon_rd;
   logic [DW-1:0] mon_data;
   logic          mon_err;
   string         mon_name;

   always @(negedge PCLK) begin
      if (!PRESET && PSEL && PENABLE && PREADY) begin
         if (exp_rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got addr=%h expected no transfer", PADDR);
         end else begin
            mon_rd   = exp_rd_q.pop_front();
            mon_data = exp_data_q.pop_front();
            mon_err  = exp_err_q.pop_front();
            mon_name = exp_name_q.pop_front();
            chk({mon_name, "_slverr"}, DW'(PSLVERR), DW'(mon_err));
            if (mon_rd) chk(mon_name, PRDATA, mon_data);
         end
      end
   end

   task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic err, input string name);
      exp_rd_q.push_back(1'b0);
      exp_data_q.push_back('0);
      exp_err_q.push_back(err);
      exp_name_q.push_back(name);
      apb_xfer(1'b1, a, wd);
   endtask

   task automatic apb_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input logic err, input string name);
      exp_rd_q.push_back(1'b1);
      exp_data_q.push_back(exp);
      exp_err_q.push_back(err);
      exp_name_q.push_back(name);
      apb_xfer(1'b0, a, '0);
   endtask

   task automatic read_all_zero(input string name);
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < 4; r++)
            apb_read(AW'(c * 16 + r * 4), '0, 1'b0, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;

      // reset state and address map
      chk("rst_ovf", DW'(TMR_OVF), 0);
      chk("rst_urf", DW'(TMR_URF), 0);
      chk("rst_irq", DW'(TMR_IRQ), 0);
      chk("rst_pready", DW'(PREADY), 1);
      read_all_zero("rst_rd");
      apb_read (8'h20, 32'h0, 1'b1, "unmap_rd");
      apb_write(8'h44, 32'hFF, 1'b1, "unmap_wr");
      apb_read (8'h04, 32'h0, 1'b0, "tcr0_after_unmap");
      apb_write(8'h14, 32'hFFFF_FFFF, 1'b0, "tcr1_all_ones");
      apb_read (8'h14, 32'h0000_00FB, 1'b0, "tcr1_mask");
      apb_write(8'h14, 32'h0, 1'b0, "tcr1_clr");
      apb_write(8'h18, 32'h3, 1'b0, "tsr1_clr");
      apb_write(8'h1C, 32'h0, 1'b0, "tcnt1_clr");
      apb_read (8'h18, 32'h0, 1'b0, "tsr1_clean");
      apb_read (8'h1C, 32'h0, 1'b0, "tcnt1_clean");

      // load then up-count for 10 enabled edges at CKS=0
      apb_write(8'h00, 32'h0000_0100, 1'b0, "tdr0_wr");
      apb_write(8'h04, 32'h0000_0080, 1'b0, "tcr0_load");
      apb_read (8'h0C, 32'h0000_0100, 1'b0, "tcnt0_loaded");
      apb_write(8'h04, 32'h0000_0010, 1'b0, "tcr0_en");
      repeat (7) @(posedge PCLK);
      apb_write(8'h04, 32'h0000_0000, 1'b0, "tcr0_dis");
      apb_read (8'h0C, 32'h0000_0105, 1'b0, "tcnt0_upcount");

      // overflow with auto-reload, 4 enabled edges = 2 ticks
      apb_write(8'h0C, 32'h0000_FFFE, 1'b0, "tcnt0_wr");
      apb_write(8'h00, 32'hABCD_1234, 1'b0, "tdr0_trunc");
      apb_write(8'h04, 32'h0000_0058, 1'b0, "tcr0_arld");
      repeat (1) @(posedge PCLK);
      apb_write(8'h04, 32'h0000_0048, 1'b0, "tcr0_stop");
      apb_read (8'h0C, 32'h0000_1234, 1'b0, "tcnt0_reload");
      apb_read (8'h00, 32'h0000_1234, 1'b0, "tdr0_rd");
      apb_read (8'h08, 32'h0000_0001, 1'b0, "tsr0_ovf");
      chk("ovf_out", DW'(TMR_OVF), 32'h1);
      chk("ovf_irq", DW'(TMR_IRQ), 32'h1);
      chk("ovf_urf", DW'(TMR_URF), 32'h0);
      apb_read (8'h1C, 32'h0, 1'b0, "tcnt1_untouched");

      // underflow without reload, 32 enabled edges at CKS=3 = 2 ticks
      apb_write(8'h1C, 32'h0000_0001, 1'b0, "tcnt1_wr");
      apb_write(8'h14, 32'h0000_0033, 1'b0, "tcr1_down");
      repeat (29) @(posedge PCLK);
      apb_write(8'h14, 32'h0000_0020, 1'b0, "tcr1_stop");
      apb_read (8'h1C, 32'h0000_FFFF, 1'b0, "tcnt1_udf");
      apb_read (8'h18, 32'h0000_0002, 1'b0, "tsr1_udf");
      chk("udf_urf", DW'(TMR_URF), 32'h2);
      chk("udf_ovf", DW'(TMR_OVF), 32'h1);
      chk("udf_irq", DW'(TMR_IRQ), 32'h1);

      // write-1-to-clear
      apb_write(8'h08, 32'h0000_0001, 1'b0, "tsr0_w1c");
      apb_read (8'h08, 32'h0, 1'b0, "tsr0_cleared");
      chk("w1c_ovf", DW'(TMR_OVF), 32'h0);
      chk("w1c_irq", DW'(TMR_IRQ), 32'h0);
      apb_write(8'h18, 32'h0000_0001, 1'b0, "tsr1_w1c_other");
      apb_read (8'h18, 32'h0000_0002, 1'b0, "tsr1_kept");

      // set-versus-clear: W1C lands on the overflow edge (CKS=3, P=15)
      apb_write(8'h0C, 32'h0000_FFFF, 1'b0, "tcnt0_max");
      n = 0;
      @(negedge PCLK);
      while (pcnt != 4'd10 && n < 40) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL align_timeout: got pcnt=%0d expected 10", pcnt);
      end
      apb_write(8'h04, 32'h0000_001B, 1'b0, "tcr0_race_en");
      apb_write(8'h08, 32'h0000_0001, 1'b0, "tsr0_race_w1c");
      apb_read (8'h08, 32'h0000_0001, 1'b0, "tsr0_set_wins");
      chk("race_ovf", DW'(TMR_OVF), 32'h1);
      apb_read (8'h0C, 32'h0, 1'b0, "tcnt0_wrap");

      // asynchronous reset mid-count
      apb_write(8'h0C, 32'h0000_0055, 1'b0, "tcnt0_55");
      #1;
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = 8'h0C;
      #1;
      chk("pre_rst_cnt", PRDATA, 32'h55);
      PRESET = 1'b1;
      #1;
      chk("async_rst_cnt", PRDATA, 32'h0);
      chk("async_rst_ovf", DW'(TMR_OVF), 32'h0);
      chk("async_rst_urf", DW'(TMR_URF), 32'h0);
      chk("async_rst_irq", DW'(TMR_IRQ), 32'h0);
      chk("async_rst_pready", DW'(PREADY), 32'h1);
      PSEL = 1'b0;
      #1;
      chk("async_rst_prdata_idle", PRDATA, 32'h0);
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
      read_all_zero("post_rst_rd");

      repeat (2) @(posedge PCLK);
      if (exp_rd_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_rd_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
